rr_arbiter4_idx: RTL
====================

Name: rr_arbiter4_idx

Overview:
- Four-requester round-robin arbiter that emits the winner as a 2-bit binary index plus a valid flag.
- Sits directly upstream of the 2-to-4 decoder: gnt_idx drives the decoder's 2-bit select, and the decoder's one-hot output, gated by gnt_valid, forms the per-requester grant lines.
- Holds a grant until the owner releases it, drops its request, or exceeds a hold-time limit.
- Fairness is rotating priority starting after the last owner.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the limit.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  4  request vector, bit i = requester i.
- done  in  1  single-cycle release pulse from the current owner.
- gnt_idx  out  2  index of the current owner; feeds the decoder select.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (immediate on rst_n low, independent of clk):
  - state = IDLE, gnt_idx = 2'd0, gnt_valid = 0, timeout = 0.
  - last pointer = 2'd3, so requester 0 has first priority after reset.
  - hold counter = 0.
- All outputs are registered; there is no combinational path from req or done to any output.
- State IDLE:
  - If req == 0, remain in IDLE with gnt_valid = 0.
  - Otherwise select the first set bit scanning last+1, last+2, last+3, last, all modulo 4.
  - Next edge: gnt_idx = winner, gnt_valid = 1, counter = 0, go to GRANT.
  - Latency from req asserted to gnt_valid is 1 cycle.
- State GRANT: gnt_idx is frozen. Release occurs at the next edge on any of these conditions:
  - done = 1;
  - req[gnt_idx] = 0 (owner withdrew);
  - MAX_HOLD != 0 and counter == MAX_HOLD - 1 and no done.
- On release:
  - last = gnt_idx, gnt_valid = 0, go to IDLE.
  - gnt_idx keeps its value; it is don't-care while gnt_valid = 0.
  - timeout = 1 for exactly that cycle only when the release cause is the hold limit alone. If done or withdrawal coincides with the limit, the release is normal and timeout = 0.
- Otherwise the counter increments by 1 and stays in GRANT. The counter cannot wrap, given the CNT_W constraint.
- Between consecutive grants there is always at least one IDLE cycle with gnt_valid = 0. This guarantees the downstream decoder's one-hot output never switches owners without a gap.
- done received while in IDLE is ignored.
- Requests that change during GRANT do not affect the owner; they are evaluated in the next IDLE cycle using the updated last pointer.
- Reset asserted mid-grant: gnt_valid drops immediately and the last pointer returns to 3. A requester that was granted before reset is not remembered.
- Arithmetic: last+k is modulo 4 (natural 2-bit wrap from 3 to 0).

Test Plan:
- Reset then req = 4'b1111 -> gnt_idx 0 valid at cycle 1. With done pulses, the grant sequence is 0, 1, 2, 3, 0, each grant separated by one IDLE cycle.
- Reset, req = 4'b0100 held, no done, MAX_HOLD = 16 -> gnt_idx 2 for exactly 16 cycles. Then gnt_valid drops and timeout pulses once. Next grant is 2 again after the IDLE cycle.
- Owner 1 granted, req[1] deasserted mid-grant -> gnt_valid low next edge, timeout = 0, last = 1. With req = 4'b0011, the next grant is 0.
- done and hold limit in the same cycle -> release with timeout = 0.
- rst_n pulsed low mid-grant (asynchronously, between edges) -> gnt_valid = 0 before the next clk edge. After release, req = 4'b1000 grants 3 and req = 4'b1111 grants 0.
- Decoder integration: drive the decoder with gnt_idx and AND its output with gnt_valid over 200 cycles of random req/done -> at most one grant line is high per cycle. Every requester holding req continuously is granted within 4 arbitration rounds.

Source files
------------

// File: rtl/rr_arbiter4_idx.sv
// Four-requester round-robin arbiter with a binary-index grant output.
// The winner is presented as gnt_idx plus gnt_valid, intended to drive the
// select of a 2-to-4 decoder whose one-hot output, gated by gnt_valid, forms
// the per-requester grant lines. A grant is held until the owner pulses done,
// drops its request, or reaches the MAX_HOLD cycle limit. Every release passes
// through at least one IDLE cycle, so the decoded grant lines never hand over
// directly from one owner to another.
module rr_arbiter4_idx #(
    parameter int MAX_HOLD = 16,  // cycles a grant may be held; 0 = unlimited
    parameter int CNT_W    = 5    // hold counter width, 2**CNT_W > MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value on the final permitted cycle of a grant.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam bit               HOLD_EN   = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       winner;
    logic             winner_found;
    logic             owner_gone;
    logic             hold_hit;

    // Rotating-priority scan: last+1, last+2, last+3, then last itself.
    always_comb begin
        winner       = last_q;
        winner_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            // The 2-bit sum wraps naturally, so k = 4 lands back on last_q.
            if (!winner_found && req[last_q + 2'(k)]) begin
                winner       = last_q + 2'(k);
                winner_found = 1'b1;
            end
        end
    end

    assign owner_gone = !req[gnt_idx_q];
    assign hold_hit   = HOLD_EN && (cnt_q == HOLD_LAST);

    // Next-state logic: arbitrate in IDLE, watch for release in GRANT.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // done arriving here has no owner to release and is ignored.
                if (winner_found) begin
                    gnt_idx_d = winner;
                    cnt_d     = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (done || owner_gone || hold_hit) begin
                    // gnt_idx is left as is; it is don't-care while invalid.
                    state_d   = IDLE;
                    last_d    = gnt_idx_q;
                    // Forced release is flagged only when the limit is the sole cause.
                    timeout_d = hold_hit && !done && !owner_gone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; last_q restarts at 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values computed by the combinational block.
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_idx_q <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = timeout_q;

endmodule
